// File: rtl/pipeline_id_operand_pkg.sv
// Shared constants for the ID-stage operand path: writeback-select encodings,
// the hard-wired zero register index and the datapath width.
package pipeline_id_operand_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // MemtoReg selects what a MEM-stage instruction will eventually write back.
  typedef enum logic [1:0] {
    WB_ALU     = 2'b00,
    WB_MEM     = 2'b01,
    WB_PC4     = 2'b10,
    WB_PC4_ALT = 2'b11
  } memtoreg_e;

  // Link value written by jump-and-link style instructions; wraps mod 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/pipeline_regfile.sv
// Architectural register file: one synchronous write port, two combinational
// read ports with same-cycle write-through, and a raw debug read port.
module pipeline_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   raddr [2];
  logic [XLEN-1:0] rdata [2];

  // Write port: entry 0 is cleared at reset and never written afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign raddr[0]  = rd_addr_a;
  assign raddr[1]  = rd_addr_b;
  assign rd_data_a = rdata[0];
  assign rd_data_b = rdata[1];

  // Read ports: index 0 reads zero; a same-cycle write to the index is passed through.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    always_comb begin
      rdata[gi] = regs[raddr[gi]];
      if (raddr[gi] == '0) begin
        rdata[gi] = '0;
      end else if (wb_we && (wb_addr == raddr[gi])) begin
        rdata[gi] = wb_data;
      end
    end
  end

  // Debug port sees array state only, so a write shows up one cycle later.
  always_comb begin
    dbg_data = regs[dbg_addr];
    if (dbg_addr == '0) begin
      dbg_data = '0;
    end
  end

endmodule

// File: rtl/pipeline_id_operand.sv
// ID-stage operand supply: register file plus MEM/WB bypass, load-use and
// EX-dependency stall detection, and a saturating stall-cycle counter.
module pipeline_id_operand #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [1:0]       mem_memtoreg,
  input  logic [XLEN-1:0]  mem_alu_res,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic [4:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  import pipeline_id_operand_pkg::*;

  logic [4:0]       src_idx  [2];
  logic [XLEN-1:0]  rf_data  [2];
  logic [XLEN-1:0]  src_data [2];
  logic             src_hold [2];
  logic [XLEN-1:0]  mem_fwd_value;
  logic             mem_is_load;
  logic [CNT_W-1:0] stall_cnt_reg;

  pipeline_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (5)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_reg_write),
    .wb_addr   (wb_rd),
    .wb_data   (wb_data),
    .rd_addr_a (id_rs1),
    .rd_addr_b (id_rs2),
    .rd_data_a (rf_data[0]),
    .rd_data_b (rf_data[1]),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  assign src_idx[0]  = id_rs1;
  assign src_idx[1]  = id_rs2;
  assign mem_is_load = (mem_memtoreg == WB_MEM);

  // Value the MEM instruction will write back, when it is already known.
  always_comb begin
    mem_fwd_value = mem_alu_res;
    if (mem_memtoreg != WB_ALU) begin
      mem_fwd_value = XLEN'(pc_plus4(mem_pc));
    end
  end

  // Per source: MEM bypass beats the regfile (which already handles WB
  // write-through); EX producers and pending loads force a stall.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    always_comb begin
      src_data[gi] = rf_data[gi];
      src_hold[gi] = 1'b0;
      if (src_idx[gi] != REG_ZERO) begin
        if (mem_reg_write && (mem_rd == src_idx[gi]) && !mem_is_load) begin
          src_data[gi] = mem_fwd_value;
        end
        if (ex_reg_write && (ex_rd == src_idx[gi])) begin
          src_hold[gi] = 1'b1;
        end
        if (mem_reg_write && (mem_rd == src_idx[gi]) && mem_is_load) begin
          src_hold[gi] = 1'b1;
        end
      end
    end
  end

  assign rs1_data  = src_data[0];
  assign rs2_data  = src_data[1];
  assign stall     = src_hold[0] | src_hold[1];
  assign stall_cnt = stall_cnt_reg;

  // Stall-cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_id_operand.sv
// Directed bench for pipeline_id_operand: each scenario task drives inputs
// after a rising edge, lets them settle and compares against hand values.
module tb_pipeline_id_operand;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, dbg_addr;
  logic        ex_reg_write, mem_reg_write, wb_reg_write;
  logic [1:0]  mem_memtoreg;
  logic [31:0] mem_alu_res, mem_pc, wb_data;
  logic [31:0] rs1_data, rs2_data, dbg_data;
  logic        stall;
  logic [31:0] stall_cnt;

  int checks;
  int errors;

  pipeline_id_operand #(
    .XLEN  (32),
    .NREG  (32),
    .CNT_W (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_memtoreg  (mem_memtoreg),
    .mem_alu_res   (mem_alu_res),
    .mem_pc        (mem_pc),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .stall         (stall),
    .stall_cnt     (stall_cnt),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_reg_write = 0;
    mem_rd = 0; mem_reg_write = 0; mem_memtoreg = 2'b00;
    mem_alu_res = 0; mem_pc = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0; dbg_addr = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    id_rs1 = 5; id_rs2 = 0;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rs1 got %h exp %h", rs1_data, 32'h0); end
    checks++;
    if (rs2_data !== 32'h0) begin errors++; $display("FAIL reset_rs2 got %h exp %h", rs2_data, 32'h0); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_write_through();
    clear_inputs();
    wb_reg_write = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
    id_rs1 = 3; dbg_addr = 3;
    #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wt_same_cycle got %h exp %h", rs1_data, 32'hDEADBEEF); end
    checks++;
    if (dbg_data !== 32'h0) begin errors++; $display("FAIL wt_dbg_before got %h exp %h", dbg_data, 32'h0); end
    tick();
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wt_next_cycle got %h exp %h", rs1_data, 32'hDEADBEEF); end
    checks++;
    if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wt_dbg_after got %h exp %h", dbg_data, 32'hDEADBEEF); end
    $display("test_write_through done");
  endtask

  task automatic test_mem_forward();
    clear_inputs();
    mem_reg_write = 1; mem_rd = 4; mem_memtoreg = 2'b00; mem_alu_res = 32'h11;
    wb_reg_write = 1; wb_rd = 4; wb_data = 32'h22;
    id_rs2 = 4;
    #1;
    checks++;
    if (rs2_data !== 32'h11) begin errors++; $display("FAIL mem_alu_over_wb got %h exp %h", rs2_data, 32'h11); end
    mem_memtoreg = 2'b10; mem_pc = 32'hFFFFFFFC;
    #1;
    checks++;
    if (rs2_data !== 32'h0) begin errors++; $display("FAIL mem_pc4_wrap got %h exp %h", rs2_data, 32'h0); end
    mem_memtoreg = 2'b11; mem_pc = 32'h100;
    #1;
    checks++;
    if (rs2_data !== 32'h104) begin errors++; $display("FAIL mem_pc4_alt got %h exp %h", rs2_data, 32'h104); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mem_fwd_stall got %b exp 0", stall); end
    mem_reg_write = 0;
    #1;
    checks++;
    if (rs2_data !== 32'h22) begin errors++; $display("FAIL wb_fwd got %h exp %h", rs2_data, 32'h22); end
    tick();
    clear_inputs();
    $display("test_mem_forward done");
  endtask

  task automatic test_load_stall();
    clear_inputs();
    mem_reg_write = 1; mem_rd = 7; mem_memtoreg = 2'b01; mem_alu_res = 32'h99;
    id_rs1 = 7;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_stall got %b exp 1", stall); end
    tick();
    checks++;
    if (stall_cnt !== 32'd1) begin errors++; $display("FAIL load_cnt got %0d exp 1", stall_cnt); end
    mem_reg_write = 0; mem_rd = 0; mem_memtoreg = 2'b00;
    wb_reg_write = 1; wb_rd = 7; wb_data = 32'h55;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL load_release got %b exp 0", stall); end
    checks++;
    if (rs1_data !== 32'h55) begin errors++; $display("FAIL load_wb_data got %h exp %h", rs1_data, 32'h55); end
    tick();
    checks++;
    if (stall_cnt !== 32'd1) begin errors++; $display("FAIL load_cnt_hold got %0d exp 1", stall_cnt); end
    clear_inputs();
    $display("test_load_stall done");
  endtask

  task automatic test_ex_stall();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_reg_write = 1; ex_rd = 9; id_rs2 = 9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL ex_stall_%0d got %b exp 1", i, stall); end
      tick();
    end
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL ex_cnt got %0d exp 3", stall_cnt); end
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL ex_x0_stall got %b exp 0", stall); end
    ex_reg_write = 0; ex_rd = 9; id_rs2 = 9;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL ex_nowrite_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL ex_cnt_hold got %0d exp 3", stall_cnt); end
    clear_inputs();
    $display("test_ex_stall done");
  endtask

  task automatic test_x0_and_reset();
    clear_inputs();
    wb_reg_write = 1; wb_rd = 0; wb_data = 32'h1234;
    id_rs1 = 0; dbg_addr = 0;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_read got %h exp %h", rs1_data, 32'h0); end
    tick();
    wb_reg_write = 0;
    #1;
    checks++;
    if (dbg_data !== 32'h0) begin errors++; $display("FAIL x0_dbg got %h exp %h", dbg_data, 32'h0); end
    wb_reg_write = 1; wb_rd = 5; wb_data = 32'hAB;
    tick();
    wb_reg_write = 0; dbg_addr = 5;
    ex_reg_write = 1; ex_rd = 5; id_rs1 = 5;
    #1;
    checks++;
    if (dbg_data !== 32'hAB) begin errors++; $display("FAIL x5_dbg got %h exp %h", dbg_data, 32'hAB); end
    tick();
    checks++;
    if (stall_cnt !== 32'd4) begin errors++; $display("FAIL pre_rst_cnt got %0d exp 4", stall_cnt); end
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall got %b exp 1", stall); end
    tick();
    rst = 1'b0;
    ex_reg_write = 0; ex_rd = 0;
    #1;
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt); end
    for (int a = 1; a < 8; a++) begin
      dbg_addr = 5'(a);
      #1;
      checks++;
      if (dbg_data !== 32'h0) begin errors++; $display("FAIL rst_dbg_x%0d got %h exp %h", a, dbg_data, 32'h0); end
    end
    checks++;
    if (rs1_data !== 32'h0) begin errors++; $display("FAIL rst_rs1 got %h exp %h", rs1_data, 32'h0); end
    $display("test_x0_and_reset done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_write_through();
    test_mem_forward();
    test_load_stall();
    test_ex_stall();
    test_x0_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_id_operand.md
Name: pipeline_id_operand

Overview:
- ID-stage operand source and the read-side counterpart of the writeback mux.
- Holds the 32x32 architectural register file and accepts the WB-stage write (wb_data, rd, RegWrite).
- Supplies rs1/rs2 operands to ID, bypassing younger MEM/WB results.
- Raises a stall when an operand cannot be supplied this cycle; counts stall cycles for performance debug.

Parameters:
- XLEN, 32, data width.
- NREG, 32, register count (index width = 5).
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- id_rs1  in  5  ID source register 1 index.
- id_rs2  in  5  ID source register 2 index.
- ex_rd  in  5  destination of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes rd.
- mem_rd  in  5  destination in MEM.
- mem_reg_write  in  1  MEM instruction writes rd.
- mem_memtoreg  in  2  MEM writeback select (00 ALU, 01 load, 10/11 PC+4).
- mem_alu_res  in  32  MEM ALU result.
- mem_pc  in  32  MEM instruction PC.
- wb_rd  in  5  WB destination.
- wb_reg_write  in  1  WB write enable.
- wb_data  in  32  final writeback value.
- rs1_data  out  32  operand 1 to ID/EX.
- rs2_data  out  32  operand 2 to ID/EX.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- stall_cnt  out  CNT_W  cycles with stall=1 since reset.
- dbg_addr  in  5  debug read index.
- dbg_data  out  32  debug read of the register array (no bypass).

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - all registers <= 0.
  - stall_cnt <= 0.
  - Outputs are combinational from zeroed state: rs*_data=0 unless bypassed, dbg_data=0.
- Register write:
  - At the clk edge, if wb_reg_write && wb_rd!=0, then reg[wb_rd] <= wb_data.
  - x0 always reads 0, is never written, and is never a forwarding or stall match.
- Operand select (combinational, per source s in {rs1, rs2}), priority high to low:
  1. s==0 -> 0.
  2. mem_reg_write && mem_rd==s && mem_memtoreg!=01 -> mem_alu_res when memtoreg=00; mem_pc+4 (mod 2^32) when 10/11.
  3. wb_reg_write && wb_rd==s -> wb_data (same-cycle write-through).
  4. Otherwise reg[s].
- Stall (combinational, s nonzero):
  - stall=1 if ex_reg_write && ex_rd==s for either source; the EX result is not forwardable to ID.
  - stall=1 if mem_reg_write && mem_rd==s && mem_memtoreg==01; load data is not ready until WB.
  - While stall=1, rs*_data values are don't-care, and the pipeline must not capture them.
- stall_cnt:
  - Increments by 1 at each edge where stall=1 and rst=0.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - A WB write and a read of the same register in one cycle returns the new wb_data.
  - A MEM match overrides a WB match for the same index (younger wins).
  - rst asserted mid-stall clears the counter; register contents are cleared at that same edge.
- dbg_data = reg[dbg_addr] from array state only (0 for index 0); reflects a write on the following cycle.

Decomposition:
- Shared package holds:
  - MemtoReg encodings: WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10, WB_PC4_ALT=2'b11.
  - REG_ZERO=5'd0.
  - XLEN.
- One sub-module: pipeline_regfile (array, write port, write-through read ports, debug port).
- Forwarding and stall logic stay in the top module.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> rs1_data=0, rs2_data=0, stall=0, stall_cnt=0.
- WB write x3=0xDEADBEEF while id_rs1=3 in the same cycle -> rs1_data=0xDEADBEEF that cycle; next cycle (no WB) still 0xDEADBEEF; dbg_addr=3 reads 0xDEADBEEF.
- MEM rd=4, memtoreg=00, alu_res=0x11 and WB rd=4 data=0x22, id_rs2=4 -> rs2_data=0x11; change memtoreg to 10 with mem_pc=0xFFFFFFFC -> rs2_data=0x0.
- MEM load (memtoreg=01) rd=7, id_rs1=7 -> stall=1 and stall_cnt increments; the following cycle with WB rd=7 data=0x55 and MEM cleared -> stall=0, rs1_data=0x55.
- ex_reg_write=1, ex_rd=9, id_rs2=9 for 3 cycles -> stall=1 each cycle, stall_cnt=3; ex_rd=0 with id_rs1=0 -> no stall.
- WB write to x0 with data 0x1234 -> dbg x0 reads 0 and rs1=0 reads 0; rst asserted while stall=1 -> stall_cnt=0 and all dbg reads 0 next cycle.
